viol_reset_sequencer: RTL

- Central reset sequencer for the security monitors (PoR/ER/DMA/stack monitors).
- Each monitor raises a violation bit. This block picks one cause, holds the MCU system reset for a fixed stretch, then releases it.
- It checks that the core re-enters through the reset vector, and records cause and violation count for the attestation report.
- Sits between the monitor bank and the core's reset input.

---
 rtl/viol_reset_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/viol_reset_sequencer.sv
// Reset sequencer between the security monitor bank and the MCU core: latches a violation
// cause, stretches sys_rst, and checks that the core re-enters at RESET_HANDLER. Option macro: VIOL_COMB_KILL_EN.
module viol_reset_sequencer #(
  parameter int          NUM_MON       = 4,
  parameter int          CID_W         = 3,
  parameter int          RST_CYCLES    = 8,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
  parameter int          WAIT_TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        pc,
  input  logic [NUM_MON-1:0] viol,
  input  logic               cause_clr,
  output logic               sys_rst,
  output logic               cause_vld,
  output logic [CID_W-1:0]   cause_id,
  output logic [7:0]         viol_count,
  output logic               running,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [7:0]         to_cnt_q, to_cnt_d;
  logic               sys_rst_q;
  logic               cause_vld_q, cause_vld_d;
  logic [CID_W-1:0]   cause_id_q, cause_id_d;
  logic [7:0]         viol_count_q, viol_count_d;
  logic               accept;
  logic [CID_W-1:0]   viol_id;

  // Fixed priority: bit 0 wins, so scan from the top down and let lower bits overwrite.
  always_comb begin
    viol_id = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (viol[i]) viol_id = CID_W'(i);
    end
  end

  assign accept = (state_q != S_HOLD) && (|viol);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= 8'(RST_CYCLES);
      to_cnt_q     <= 8'd0;
      sys_rst_q    <= 1'b1;
      cause_vld_q  <= 1'b0;
      cause_id_q   <= '0;
      viol_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      to_cnt_q     <= to_cnt_d;
      sys_rst_q    <= (state_d == S_HOLD);
      cause_vld_q  <= cause_vld_d;
      cause_id_q   <= cause_id_d;
      viol_count_q <= viol_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    to_cnt_d     = to_cnt_q;
    cause_vld_d  = cause_vld_q;
    cause_id_d   = cause_id_q;
    viol_count_d = viol_count_q;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == 8'd1) begin
          state_d    = S_RELEASE;
          hold_cnt_d = 8'(RST_CYCLES);
          to_cnt_d   = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      S_RELEASE: begin
        if (accept) begin
          state_d  = S_HOLD;
          to_cnt_d = 8'd0;
        end else if (pc == RESET_HANDLER) begin
          state_d  = S_RUN;
          to_cnt_d = 8'd0;
        end else if (to_cnt_q == 8'(WAIT_TIMEOUT - 1)) begin
          state_d    = S_HOLD;
          to_cnt_d   = 8'd0;
          hold_cnt_d = 8'(RST_CYCLES);
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (accept) begin
          state_d = S_HOLD;
        end else if (cause_clr) begin
          cause_vld_d = 1'b0;
          cause_id_d  = '0;
        end
      end
      default: begin
        state_d    = S_HOLD;
        hold_cnt_d = 8'(RST_CYCLES);
      end
    endcase
    if (accept) begin
      cause_vld_d  = 1'b1;
      cause_id_d   = viol_id;
      viol_count_d = (viol_count_q == 8'hFF) ? 8'hFF : viol_count_q + 8'd1;
      hold_cnt_d   = 8'(RST_CYCLES);
    end
  end

  always_comb begin
`ifdef VIOL_COMB_KILL_EN
    // Zero-latency kill: a violation seen in RUN asserts reset before the register catches up.
    sys_rst = sys_rst_q | ((state_q == S_RUN) & (|viol));
`else
    sys_rst = sys_rst_q;
`endif
    running    = (state_q == S_RUN);
    cause_vld  = cause_vld_q;
    cause_id   = cause_id_q;
    viol_count = viol_count_q;
    dbg_state  = state_q;
  end

endmodule
